id_ex_skid_reg: RTL and testbench
=================================

// Module: id_ex_skid_reg
// PURPOSE
//  Decode->execute pipeline register for the RV32I core. Built as a 2-entry skid buffer with valid/ready handshake and flush.
//  Sits directly upstream of the execute-stage 3-bit select muxes: ex_funct3/ex_op3 feed their A/B inputs, ex_sel drives sel.
//  Registers id_ready, so there is no combinational path from execute back-pressure to decode.
// PARAMETERS
//  XLEN  32  data/address width (pc, rs1, rs2, imm)
//  RD_W  5   destination register index width
// PORTS
//  clk        in   1     single clock, all state updates on posedge
//  rst_n      in   1     synchronous reset, active-low
//  flush      in   1     sync pipeline flush (branch/jump redirect)
//  id_valid   in   1     decode offers a beat
//  id_ready   out  1     block can accept a beat (registered)
//  id_pc      in   XLEN  instruction PC
//  id_rs1     in   XLEN  rs1 operand value
//  id_rs2     in   XLEN  rs2 operand value
//  id_imm     in   XLEN  sign-extended immediate
//  id_funct3  in   3     instruction funct3
//  id_op3     in   3     alternate 3-bit ALU op (override path)
//  id_sel     in   1     0 selects funct3, 1 selects op3 downstream
//  id_rd      in   RD_W  destination register index
//  ex_valid   out  1     execute beat valid
//  ex_ready   in   1     execute accepts beat
//  ex_pc, ex_rs1, ex_rs2, ex_imm, ex_funct3, ex_op3, ex_sel, ex_rd  out  (widths as id_*)  registered payload
// BEHAVIOUR
//  - in = id_valid & id_ready; out = ex_valid & ex_ready. Payload P = all id_* data fields.
//  - Two slots: main (drives ex_*), skid. States: EMPTY, ONE (main only), FULL (main+skid).
//  - id_ready = !skid_valid (1 in EMPTY/ONE, 0 in FULL). ex_valid = main_valid.
//  - EMPTY: in -> ONE, main<=P.
//  - ONE: in&out -> ONE, main<=P; in&!out -> FULL, skid<=P; !in&out -> EMPTY; else hold.
//  - FULL: out -> ONE, main<=skid; else hold. in is impossible (id_ready=0).
//  - Strict FIFO order; no beat dropped or duplicated. Latency is 1 cycle from accept to ex_valid when main is free/draining.
//  - ex_* stable while ex_valid & !ex_ready. Payload regs load only on slot load.
//    Emptied slots keep stale data; downstream qualifies with ex_valid.
//  - Priority: reset > flush > handshake.
//  - Flush: next cycle EMPTY, id_ready=1, ex_valid=0. A beat offered in the flush cycle is dropped.
//    An out handshake in the flush cycle is consumed by execute, no extra effect.
//  - Reset (posedge with rst_n=0): EMPTY; ex_valid=0, id_ready=1.
//    All ex_* payload outputs =0 (ex_sel=0 -> mux selects funct3).
//    Reset mid-operation discards both slots.
//  - Upstream holds id_* stable while id_valid & !id_ready; the block does not check this.
//  - Invariant (sim assertion): skid_valid -> main_valid.
// STRUCTURE
//  - Package rv_pipe_pkg: XLEN, RD_W constants.
//    Typedef id_ex_payload_t (pc, rs1, rs2, imm, funct3, op3, sel, rd).
//    Enum skid_state_t {S_EMPTY, S_ONE, S_FULL}.
//  - No sub-module. Single always block for state/valids plus slot register loads.
//    State encoded as two valid bits.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with id_valid=1 -> ex_valid=0, id_ready=1, ex_funct3=0, ex_sel=0 after release.
//  2 Stream: ex_ready=1, funct3=0..7 back-to-back -> ex_funct3 0..7 one per cycle from cycle+1, id_ready stays 1.
//  3 Backpressure: ex_ready=0, send A(funct3=3), B(funct3=5) -> id_ready=0 after B, ex_funct3 holds 3.
//    Raise ex_ready -> 3 then 5 on consecutive cycles, id_ready=1 the cycle after 3 drains.
//  4 Flush in FULL with id_valid=1 (funct3=6) -> next cycle ex_valid=0, id_ready=1, beat 6 never appears.
//    Next beat (funct3=2) appears 1 cycle after accept.
//  5 Reset mid-FULL (pc=0x100, 0x104 held) -> EMPTY, ex_pc=0; neither beat emitted afterwards.
//  6 Random: 1000 cycles of random id_valid/ex_ready/flush (5%) vs scoreboard model.
//    No drop/dup/reorder except flushed beats; ex_* stable under stall.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg
// Shared definitions for the RV32I decode->execute pipeline boundary.
//   XLEN            data/address width (pc, rs1, rs2, imm)
//   RD_W            destination register index width
//   id_ex_payload_t everything decode hands to execute for one instruction
//   skid_state_t    occupancy of the two-entry id/ex skid buffer
package rv_pipe_pkg;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic [2:0]      op3;
        logic            sel;
        logic [RD_W-1:0] rd;
    } id_ex_payload_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } skid_state_t;

endpackage

// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg
// Decode->execute pipeline register built as a two-entry skid buffer.
// The main slot drives the ex_* outputs; the skid slot catches the one beat
// that decode can still push in the cycle execute stalls, which lets id_ready
// come straight from a flop instead of from ex_ready.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop everything in flight (branch/jump redirect)
//   id_valid / id_ready  decode-side handshake (id_ready is registered)
//   id_pc .. id_rd       decode payload
//   ex_valid / ex_ready  execute-side handshake
//   ex_pc .. ex_rd       registered payload from the main slot
module id_ex_skid_reg
    import rv_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1,
    input  logic [XLEN-1:0] id_rs2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [2:0]      id_funct3,
    input  logic [2:0]      id_op3,
    input  logic            id_sel,
    input  logic [RD_W-1:0] id_rd,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] ex_rs2,
    output logic [XLEN-1:0] ex_imm,
    output logic [2:0]      ex_funct3,
    output logic [2:0]      ex_op3,
    output logic            ex_sel,
    output logic [RD_W-1:0] ex_rd
);

    id_ex_payload_t in_payload;
    id_ex_payload_t main_q;
    id_ex_payload_t skid_q;

    logic        main_valid;
    logic        skid_valid;
    logic        main_valid_nxt;
    logic        skid_valid_nxt;
    logic        load_main_in;
    logic        load_main_skid;
    logic        load_skid;
    logic        in_fire;
    logic        out_fire;
    skid_state_t state;

    assign in_payload = '{pc: id_pc, rs1: id_rs1, rs2: id_rs2, imm: id_imm,
                          funct3: id_funct3, op3: id_op3, sel: id_sel, rd: id_rd};

    // The skid slot only fills when decode pushed while execute stalled,
    // so its valid bit is exactly "cannot take another beat".
    assign id_ready = !skid_valid;
    assign ex_valid = main_valid;
    assign in_fire  = id_valid & id_ready;
    assign out_fire = main_valid & ex_ready;

    // The two valid bits are the state; decode them into the named states
    // so the transition table below reads like the occupancy diagram.
    always_comb begin
        state = S_EMPTY;
        if (main_valid && skid_valid) begin
            state = S_FULL;
        end else if (main_valid) begin
            state = S_ONE;
        end
    end

    // Next occupancy and which slot loads what. A flush wins over any
    // handshake: both slots empty and nothing is captured that cycle.
    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (in_fire) begin
                    main_valid_nxt = 1'b1;
                    load_main_in   = 1'b1;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in   = 1'b1;
                end else if (in_fire) begin
                    skid_valid_nxt = 1'b1;
                    load_skid      = 1'b1;
                end else if (out_fire) begin
                    main_valid_nxt = 1'b0;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    skid_valid_nxt = 1'b0;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                main_valid_nxt = 1'b0;
                skid_valid_nxt = 1'b0;
            end
        endcase
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Valid bits and slot payloads. Payload flops only move on a slot load,
    // so ex_* stay frozen while execute stalls and emptied slots keep stale
    // data. Reset zeroes the payload so ex_sel comes up selecting funct3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (load_main_in) begin
                main_q <= in_payload;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_payload;
            end
        end
    end

    assign ex_pc     = main_q.pc;
    assign ex_rs1    = main_q.rs1;
    assign ex_rs2    = main_q.rs2;
    assign ex_imm    = main_q.imm;
    assign ex_funct3 = main_q.funct3;
    assign ex_op3    = main_q.op3;
    assign ex_sel    = main_q.sel;
    assign ex_rd     = main_q.rd;

`ifndef SYNTHESIS
    // A beat can only sit in the skid slot behind one in the main slot.
    skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n)
        skid_valid |-> main_valid);
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb_id_ex_skid_reg
// Directed vector table for reset / streaming / backpressure / flush,
// a hand-written reset-while-full sequence, then random traffic compared
// against an in-order queue model of the buffer.
module tb_id_ex_skid_reg;
    import rv_pipe_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1;
    logic [XLEN-1:0] id_rs2;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_funct3;
    logic [2:0]      id_op3;
    logic            id_sel;
    logic [RD_W-1:0] id_rd;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_imm;
    logic [2:0]      ex_funct3;
    logic [2:0]      ex_op3;
    logic            ex_sel;
    logic [RD_W-1:0] ex_rd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_skid_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm),
        .id_funct3(id_funct3), .id_op3(id_op3), .id_sel(id_sel), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .ex_funct3(ex_funct3), .ex_op3(ex_op3), .ex_sel(ex_sel), .ex_rd(ex_rd)
    );

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       id_valid;
        logic       ex_ready;
        logic [2:0] f3;
        logic       exp_valid;
        logic       exp_ready;
        logic       chk_f3;
        logic [2:0] exp_f3;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic er, input logic [2:0] f3,
                                input logic ev, input logic ir,
                                input logic cf, input logic [2:0] ef3,
                                input string nm);
        vec_t v;
        v.rst_n = r; v.flush = f; v.id_valid = iv; v.ex_ready = er; v.f3 = f3;
        v.exp_valid = ev; v.exp_ready = ir; v.chk_f3 = cf; v.exp_f3 = ef3;
        v.name = nm;
        return v;
    endfunction

    // Directed payloads are tagged by funct3 so every field is recognisable.
    function automatic id_ex_payload_t tagged_payload(input logic [2:0] f3);
        id_ex_payload_t p;
        p.pc     = 32'h1000 + 32'(f3) * 4;
        p.rs1    = 32'hA000_0000 | 32'(f3);
        p.rs2    = 32'hB000_0000 | 32'(f3);
        p.imm    = 32'hC000_0000 | 32'(f3);
        p.funct3 = f3;
        p.op3    = ~f3;
        p.sel    = f3[0];
        p.rd     = 5'(f3) + 5'd1;
        return p;
    endfunction

    function automatic id_ex_payload_t random_payload();
        id_ex_payload_t p;
        p.pc     = $urandom;
        p.rs1    = $urandom;
        p.rs2    = $urandom;
        p.imm    = $urandom;
        p.funct3 = 3'($urandom);
        p.op3    = 3'($urandom);
        p.sel    = 1'($urandom);
        p.rd     = 5'($urandom);
        return p;
    endfunction

    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic er, input id_ex_payload_t p);
        rst_n     = r;
        flush     = f;
        id_valid  = iv;
        ex_ready  = er;
        id_pc     = p.pc;
        id_rs1    = p.rs1;
        id_rs2    = p.rs2;
        id_imm    = p.imm;
        id_funct3 = p.funct3;
        id_op3    = p.op3;
        id_sel    = p.sel;
        id_rd     = p.rd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkPayload(input string name, input id_ex_payload_t exp);
        id_ex_payload_t act;
        act = '{pc: ex_pc, rs1: ex_rs1, rs2: ex_rs2, imm: ex_imm,
                funct3: ex_funct3, op3: ex_op3, sel: ex_sel, rd: ex_rd};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got pc=0x%0h f3=%0d rd=%0d expected pc=0x%0h f3=%0d rd=%0d",
                     name, act.pc, act.funct3, act.rd, exp.pc, exp.funct3, exp.rd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        id_ex_payload_t model_q[$];
        id_ex_payload_t p;
        logic           r_flush;
        logic           r_iv;
        logic           r_er;
        logic           acc;
        logic           drn;

        // Reset held two cycles with decode offering a beat.
        vecs.push_back(mk(0, 0, 1, 1, 3'd7, 0, 1, 1, 3'd0, "reset0"));
        vecs.push_back(mk(0, 0, 1, 1, 3'd7, 0, 1, 1, 3'd0, "reset1"));
        vecs.push_back(mk(1, 0, 0, 1, 3'd7, 0, 1, 1, 3'd0, "post_reset"));
        // Back-to-back stream, one beat out per cycle.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 0, 1, 1, 3'(i), 1, 1, 1, 3'(i), "stream"));
        end
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 0, 1, 0, 3'd0, "stream_drain"));
        // Backpressure: A=3, B=5 stack up, then drain in order.
        vecs.push_back(mk(1, 0, 1, 0, 3'd3, 1, 1, 1, 3'd3, "bp_a"));
        vecs.push_back(mk(1, 0, 1, 0, 3'd5, 1, 0, 1, 3'd3, "bp_b"));
        vecs.push_back(mk(1, 0, 0, 0, 3'd0, 1, 0, 1, 3'd3, "bp_hold"));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 1, 1, 1, 3'd5, "bp_drain3"));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 0, 1, 0, 3'd0, "bp_drain5"));
        // Flush while full with a beat (6) offered; 1 and 4 and 6 vanish.
        vecs.push_back(mk(1, 0, 1, 0, 3'd1, 1, 1, 1, 3'd1, "fl_a"));
        vecs.push_back(mk(1, 0, 1, 0, 3'd4, 1, 0, 1, 3'd1, "fl_b"));
        vecs.push_back(mk(1, 1, 1, 0, 3'd6, 0, 1, 0, 3'd0, "flush"));
        vecs.push_back(mk(1, 0, 1, 1, 3'd2, 1, 1, 1, 3'd2, "after_flush"));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 0, 1, 0, 3'd0, "flush_empty0"));
        vecs.push_back(mk(1, 0, 0, 1, 3'd0, 0, 1, 0, 3'd0, "flush_empty1"));

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tagged_payload(3'd0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].flush, vecs[i].id_valid,
                          vecs[i].ex_ready, tagged_payload(vecs[i].f3));
            tick();
            checkOutput({vecs[i].name, ".ex_valid"}, 32'(ex_valid), 32'(vecs[i].exp_valid));
            checkOutput({vecs[i].name, ".id_ready"}, 32'(id_ready), 32'(vecs[i].exp_ready));
            if (vecs[i].chk_f3) begin
                checkOutput({vecs[i].name, ".ex_funct3"}, 32'(ex_funct3), 32'(vecs[i].exp_f3));
                checkOutput({vecs[i].name, ".ex_sel"}, 32'(ex_sel), 32'(vecs[i].exp_f3[0]));
            end
        end

        // Reset while full: pc 0x100 in main, 0x104 in skid.
        p = tagged_payload(3'd0);
        p.pc = 32'h100;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, p);
        tick();
        p.pc = 32'h104;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, p);
        tick();
        checkOutput("rf_full.id_ready", 32'(id_ready), 32'd0);
        checkOutput("rf_full.ex_pc", ex_pc, 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, p);
        tick();
        checkOutput("rf_reset.ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("rf_reset.id_ready", 32'(id_ready), 32'd1);
        checkOutput("rf_reset.ex_pc", ex_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, p);
            tick();
            checkOutput("rf_after.ex_valid", 32'(ex_valid), 32'd0);
        end

        // Random traffic against an in-order queue of at most two beats.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, random_payload());
        tick();
        model_q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            r_flush = ($urandom_range(99) < 5);
            r_iv    = 1'($urandom);
            r_er    = 1'($urandom);
            p       = random_payload();
            applyStimulus(1'b1, r_flush, r_iv, r_er, p);
            acc = r_iv && (model_q.size() < 2);
            drn = r_er && (model_q.size() > 0);
            if (r_flush) begin
                model_q.delete();
            end else begin
                if (drn) void'(model_q.pop_front());
                if (acc) model_q.push_back(p);
            end
            tick();
            checkOutput("rand.ex_valid", 32'(ex_valid), 32'(model_q.size() > 0));
            checkOutput("rand.id_ready", 32'(id_ready), 32'(model_q.size() < 2));
            if (model_q.size() > 0) begin
                checkPayload("rand.payload", model_q[0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
